// File: rtl/vga_sync_monitor.sv
// VGA sync monitor: recovers active-area pixel coordinates, tracks timing lock and raises sticky
// timing/blank error flags. Define FRAME_SUM_EN to add the per-frame RGB checksum.
module vga_sync_monitor #(
    parameter int H_TOTAL     = 800,
    parameter int H_SYNC      = 96,
    parameter int H_ACT_START = 144,
    parameter int H_ACT       = 640,
    parameter int V_TOTAL     = 525,
    parameter int V_SYNC      = 2,
    parameter int V_ACT_START = 35,
    parameter int V_ACT       = 480
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        iVGA_H_SYNC,
    input  logic        iVGA_V_SYNC,
    input  logic        iVGA_BLANK,
    input  logic [7:0]  iVGA_R,
    input  logic [7:0]  iVGA_G,
    input  logic [7:0]  iVGA_B,
    input  logic        err_clr,
    output logic [9:0]  pixel_x,
    output logic [9:0]  pixel_y,
    output logic        pixel_valid,
    output logic        frame_start,
    output logic        locked,
    output logic        h_err,
    output logic        v_err,
    output logic        blank_err,
    output logic [23:0] frame_sum,
    output logic        sum_valid
);
    typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_e;

    localparam logic [9:0] CNT_MAX = 10'h3FF;

    logic       hs_q, vs_q, hs_p_q, vs_p_q, blank_q, clr_q;
    logic       h_fall, h_rise, v_fall, v_rise;
    logic [9:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic       in_win, valid, h_ev, v_ev, b_ev;
    state_e     state_q, state_d;
    logic       trk_err_q, trk_err_d;
    logic       h_err_q, h_err_d, v_err_q, v_err_d, blank_err_q, blank_err_d;
    logic [9:0] px_q, px_d, py_q, py_d;

    // Sync samples idle high in reset so releasing rst cannot fabricate an edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            hs_p_q  <= 1'b1;
            vs_p_q  <= 1'b1;
            blank_q <= 1'b0;
            clr_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking, so hs_p_q captures the old hs_q, not this edge's sample.
            hs_q    <= iVGA_H_SYNC;
            vs_q    <= iVGA_V_SYNC;
            hs_p_q  <= hs_q;
            vs_p_q  <= vs_q;
            blank_q <= iVGA_BLANK;
            clr_q   <= err_clr;
        end
    end

    // hcnt_d/vcnt_d are the coordinates of the sample currently held in hs_q/blank_q.
    always_comb begin
        // NOTE: every comb output gets a value on every path, so no latch is inferred.
        h_fall = hs_p_q & ~hs_q;
        h_rise = ~hs_p_q & hs_q;
        v_fall = vs_p_q & ~vs_q;
        v_rise = ~vs_p_q & vs_q;

        hcnt_d = h_fall ? 10'd0 : ((hcnt_q == CNT_MAX) ? CNT_MAX : hcnt_q + 10'd1);
        vcnt_d = vcnt_q;
        if (v_fall)
            vcnt_d = 10'd0;
        else if (h_fall && vcnt_q != CNT_MAX)
            vcnt_d = vcnt_q + 10'd1;

        in_win = (hcnt_d >= 10'(H_ACT_START)) && (hcnt_d < 10'(H_ACT_START + H_ACT)) &&
                 (vcnt_d >= 10'(V_ACT_START)) && (vcnt_d < 10'(V_ACT_START + V_ACT));

        h_ev = (h_fall && hcnt_q != 10'(H_TOTAL - 1)) || (h_rise && hcnt_d != 10'(H_SYNC));
        v_ev = (v_fall && vcnt_q != 10'(V_TOTAL - 1)) || (v_rise && vcnt_d != 10'(V_SYNC));
        b_ev = (state_q == LOCKED) && (blank_q != in_win);

        valid = (state_q == LOCKED) && blank_q && in_win;
        px_d  = valid ? hcnt_d - 10'(H_ACT_START) : px_q;
        py_d  = valid ? vcnt_d - 10'(V_ACT_START) : py_q;

        // A fresh error outranks a simultaneous clear.
        h_err_d     = h_ev | (h_err_q & ~clr_q);
        v_err_d     = v_ev | (v_err_q & ~clr_q);
        blank_err_d = b_ev | (blank_err_q & ~clr_q);

        trk_err_d = 1'b0;
        if (state_q == TRACK && !v_fall)
            trk_err_d = trk_err_q | h_ev | v_ev;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state_q <= SEARCH;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            SEARCH:  if (v_fall) state_d = TRACK;
            TRACK:   if (v_fall) state_d = (trk_err_q | h_ev | v_ev) ? TRACK : LOCKED;
            LOCKED:  if (h_ev | v_ev | b_ev) state_d = SEARCH;
            default: state_d = SEARCH;
        endcase
    end

    always_comb begin
        locked = (state_q == LOCKED);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hcnt_q      <= '0;
            vcnt_q      <= '0;
            trk_err_q   <= 1'b0;
            h_err_q     <= 1'b0;
            v_err_q     <= 1'b0;
            blank_err_q <= 1'b0;
            px_q        <= '0;
            py_q        <= '0;
        end else begin
            hcnt_q      <= hcnt_d;
            vcnt_q      <= vcnt_d;
            trk_err_q   <= trk_err_d;
            h_err_q     <= h_err_d;
            v_err_q     <= v_err_d;
            blank_err_q <= blank_err_d;
            px_q        <= px_d;
            py_q        <= py_d;
        end
    end

    assign pixel_valid = valid;
    assign pixel_x     = px_d;
    assign pixel_y     = py_d;
    assign frame_start = v_fall;
    assign h_err       = h_err_q;
    assign v_err       = v_err_q;
    assign blank_err   = blank_err_q;

`ifdef FRAME_SUM_EN
    logic [23:0] rgb_q, acc_q, acc_d, fsum_q, fsum_d;
    logic        sv_q, sv_d;

    always_comb begin
        acc_d  = acc_q;
        fsum_d = fsum_q;
        sv_d   = 1'b0;
        if (v_fall) begin
            fsum_d = acc_q;
            sv_d   = (state_q == LOCKED);
            acc_d  = '0;
        end else if (valid) begin
            acc_d = acc_q + rgb_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rgb_q  <= '0;
            acc_q  <= '0;
            fsum_q <= '0;
            sv_q   <= 1'b0;
        end else begin
            rgb_q  <= {iVGA_R, iVGA_G, iVGA_B};
            acc_q  <= acc_d;
            fsum_q <= fsum_d;
            sv_q   <= sv_d;
        end
    end

    assign frame_sum = fsum_q;
    assign sum_valid = sv_q;
`else
    logic unused_rgb;
    assign unused_rgb = ^{iVGA_R, iVGA_G, iVGA_B};
    assign frame_sum  = '0;
    assign sum_valid  = 1'b0;
`endif

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Scoreboard bench for vga_sync_monitor on a scaled-down raster (20 x 12, 12 x 6 active).
module tb_vga_sync_monitor;
    localparam int HT = 20, HS = 3, HAS = 5, HA = 12;
    localparam int VT = 12, VS = 2, VAS = 3, VA = 6;

    logic        clk = 1'b0;
    logic        rst, hs, vs, blank, err_clr;
    logic [7:0]  r, g, b;
    logic [9:0]  pixel_x, pixel_y;
    logic        pixel_valid, frame_start, locked, h_err, v_err, blank_err, sum_valid;
    logic [23:0] frame_sum;

    vga_sync_monitor #(
        .H_TOTAL(HT), .H_SYNC(HS), .H_ACT_START(HAS), .H_ACT(HA),
        .V_TOTAL(VT), .V_SYNC(VS), .V_ACT_START(VAS), .V_ACT(VA)
    ) dut (
        .clk(clk), .rst(rst), .iVGA_H_SYNC(hs), .iVGA_V_SYNC(vs), .iVGA_BLANK(blank),
        .iVGA_R(r), .iVGA_G(g), .iVGA_B(b), .err_clr(err_clr),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_valid(pixel_valid),
        .frame_start(frame_start), .locked(locked), .h_err(h_err), .v_err(v_err),
        .blank_err(blank_err), .frame_sum(frame_sum), .sum_valid(sum_valid)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       valid;
        logic       fs;
        logic [9:0] x;
        logic [9:0] y;
    } exp_t;

    exp_t        sb_q[$];
    logic [23:0] sum_q[$];
    int          n_checks = 0, n_fail = 0;
    logic        prev_vs;
    logic [9:0]  last_x, last_y, first_x, first_y;
    bit          end_lk, seen_first;
    logic [23:0] exp_acc, exp_sum;
    int          valid_cnt, sum_pulses = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sum_valid) begin
            sum_pulses++;
            if (sum_q.size() > 0) begin
                exp_sum = sum_q.pop_front();
                check("frame_sum", frame_sum, exp_sum);
            end else begin
                check("unexpected_sum_valid", sum_valid, 1'b0);
            end
        end
    end

    task automatic compare_head();
        exp_t o;
        if (sb_q.size() > 0) begin
            o = sb_q.pop_front();
            check("pixel_valid", pixel_valid, o.valid);
            check("frame_start", frame_start, o.fs);
            check("pixel_x", pixel_x, o.x);
            check("pixel_y", pixel_y, o.y);
            if (pixel_valid) begin
                valid_cnt++;
                if (!seen_first) begin
                    seen_first = 1'b1;
                    first_x    = pixel_x;
                    first_y    = pixel_y;
                end
            end
        end
    endtask

    // Outputs for a pixel appear one clock after it is driven, so each call first
    // retires the previous pixel's expectation, then drives and queues the new one.
    task automatic drive_pixel(input logic h, input logic v, input logic bl,
                               input logic [23:0] rgb, input logic clr, input bit lk,
                               input int l, input int p);
        exp_t e;
        bit   win;
        @(negedge clk);
        compare_head();
        hs = h; vs = v; blank = bl; {r, g, b} = rgb; err_clr = clr;
        win = (l >= VAS) && (l < VAS + VA) && (p >= HAS) && (p < HAS + HA);
        e.fs    = prev_vs & ~v;
        prev_vs = v;
        e.valid = lk & bl & win;
        if (e.valid) begin
            last_x  = 10'(p - HAS);
            last_y  = 10'(l - VAS);
            exp_acc = exp_acc + rgb;
        end
        e.x = last_x;
        e.y = last_y;
        sb_q.push_back(e);
    endtask

    task automatic drive_frame(input bit lk_in, input logic [23:0] rgb, input int n_lines,
                               input int stretch_line, input int glitch_line, input int clr_line);
        bit lk = lk_in;
        int len;
        bit glitch, win;
`ifdef FRAME_SUM_EN
        if (end_lk) sum_q.push_back(exp_acc);
`endif
        exp_acc = '0;
        for (int l = 0; l < n_lines; l++) begin
            len = (l == stretch_line) ? HT + 1 : HT;
            if (stretch_line >= 0 && l == stretch_line + 1) lk = 1'b0;
            for (int p = 0; p < len; p++) begin
                glitch = (l == glitch_line) && (p == 2);
                if (glitch) lk = 1'b0;
                win = (l >= VAS) && (l < VAS + VA) && (p >= HAS) && (p < HAS + HA);
                drive_pixel(p >= HS, l >= VS, win | glitch, rgb,
                            (l == clr_line && p == 0) || glitch, lk, l, p);
            end
        end
        end_lk = lk;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_pixel(1'b1, 1'b1, 1'b0, 24'h0, 1'b0, 1'b0, -1, -1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_locked"}, locked, 1'b0);
        check({tag, "_valid"}, pixel_valid, 1'b0);
        check({tag, "_x"}, pixel_x, 10'd0);
        check({tag, "_y"}, pixel_y, 10'd0);
        check({tag, "_fs"}, frame_start, 1'b0);
        check({tag, "_errs"}, {h_err, v_err, blank_err}, 3'b000);
        check({tag, "_sum"}, frame_sum, 24'h0);
        check({tag, "_sumv"}, sum_valid, 1'b0);
    endtask

    task automatic model_reset();
        sb_q.delete();
        hs = 1'b1; vs = 1'b1; blank = 1'b0; {r, g, b} = 24'h0; err_clr = 1'b0;
        prev_vs = 1'b1; last_x = '0; last_y = '0; end_lk = 1'b0; exp_acc = '0;
    endtask

    initial begin
        rst = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;
        idle(4);

        // Nominal: TRACK frame, then two locked frames; F0 clears start-up edge errors.
        drive_frame(1'b0, 24'h0000ff, VT, -1, -1, 3);
        check("track_not_locked", locked, 1'b0);
        valid_cnt = 0; seen_first = 1'b0;
        drive_frame(1'b1, 24'h010000, VT, -1, -1, -1);
        check("locked_f1", locked, 1'b1);
        check("valid_count_f1", valid_cnt, HA * VA);
        check("first_x", first_x, 10'd0);
        check("first_y", first_y, 10'd0);
        check("last_x", pixel_x, 10'(HA - 1));
        check("last_y", pixel_y, 10'(VA - 1));
        valid_cnt = 0;
        drive_frame(1'b1, 24'h000001, VT, -1, -1, -1);
        check("valid_count_f2", valid_cnt, HA * VA);
        check("nominal_errs", {h_err, v_err, blank_err}, 3'b000);
`ifndef FRAME_SUM_EN
        check("sum_disabled", frame_sum, 24'h0);
`endif

        // Line stretch: 21-clock line while locked.
        drive_frame(1'b1, 24'h123456, VT, 7, -1, -1);
        check("stretch_h_err", h_err, 1'b1);
        check("stretch_unlocked", locked, 1'b0);
        check("stretch_v_err", v_err, 1'b0);
        drive_frame(1'b0, 24'h000010, VT, -1, -1, 1);
        check("stretch_cleared", h_err, 1'b0);
        check("stretch_track", locked, 1'b0);
        drive_frame(1'b1, 24'h00ff00, VT, -1, -1, -1);
        check("stretch_relock", locked, 1'b1);

        // Blank glitch outside the window, coincident with err_clr.
        drive_frame(1'b1, 24'h0a0b0c, VT, -1, 4, -1);
        check("glitch_blank_err", blank_err, 1'b1);
        check("glitch_unlocked", locked, 1'b0);
        check("glitch_h_err", h_err, 1'b0);
        drive_frame(1'b0, 24'h000000, VT, -1, -1, 1);
        check("glitch_cleared", blank_err, 1'b0);
        drive_frame(1'b1, 24'hfedcba, VT, -1, -1, -1);
        check("glitch_relock", locked, 1'b1);

        // Reset mid-frame.
        drive_frame(1'b1, 24'h777777, 6, -1, -1, -1);
        check("pre_reset_locked", locked, 1'b1);
        @(negedge clk);
        #2 rst = 1'b0;
        #1 check_all_zero("midreset");
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        idle(5);
        drive_frame(1'b0, 24'h111111, VT, -1, -1, -1);
        check("post_reset_track", locked, 1'b0);
        drive_frame(1'b1, 24'h0000aa, VT, -1, -1, -1);
        check("post_reset_relock", locked, 1'b1);
        drive_frame(1'b1, 24'h000000, 3, -1, -1, -1);

        @(negedge clk);
        compare_head();
        repeat (3) @(negedge clk);
        check("sum_pulses_pending", sum_q.size(), 0);
`ifndef FRAME_SUM_EN
        check("sum_pulses_disabled", sum_pulses, 0);
        check("sum_disabled_end", frame_sum, 24'h0);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
